result_bus_arbiter: RTL and testbench
=====================================

# result_bus_arbiter

Shares the BUS_COUNT result broadcast buses among STATION_COUNT result-producing stations. Each cycle it grants up to BUS_COUNT pending requesters in round-robin order and drives the granted results onto the registered bus outputs. It sits between the execution stations and every operand-capture block listening on the result buses.

## Interface

- SIZE, 32, result value width
- STATION_INDEX_SIZE, 1, width of a station index / bus source tag
- STATION_COUNT, 2, number of requesters; must be ≤ 2**STATION_INDEX_SIZE and ≥ 1
- BUS_COUNT, 1, number of result buses; must be ≥ 1

Flat arrays pack element k at bits [k*W +: W].

- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous cancel of all in-flight broadcasts and grants
- request  in  STATION_COUNT  station j has a result pending
- request_value  in  SIZE*STATION_COUNT  result of station j; valid while request[j]=1
- grant  out  STATION_COUNT  registered one-cycle pulse: station j's result is on a bus this cycle
- bus_asserted  out  BUS_COUNT  registered: bus k carries a valid result
- bus_source  out  STATION_INDEX_SIZE*BUS_COUNT  registered: station index on bus k
- bus_value  out  SIZE*BUS_COUNT  registered: result on bus k

## Operation

- State: round-robin pointer ptr (STATION_INDEX_SIZE bits, range 0..STATION_COUNT-1), grant, and the bus output registers.
- Eligible set at an edge: request[j]=1 AND grant[j]=0. A station whose grant is currently high is never eligible, even if request is still high.
- Scan order: ptr, ptr+1, …, wrapping at STATION_COUNT (not at 2**STATION_INDEX_SIZE). The first eligible station goes to bus 0, the second to bus 1, and so on, up to BUS_COUNT stations.
- For each filled bus k: bus_asserted[k]←1, bus_source[k]←j, bus_value[k]←request_value[j], grant[j]←1.
- Unfilled buses: bus_asserted, bus_source and bus_value all ←0. Stations not granted this edge: grant←0.
- Pointer: if at least one grant, ptr←(last granted index + 1) mod STATION_COUNT. If no grants, ptr is unchanged.
- Requester contract:
  - Hold request and request_value stable until grant is seen high.
  - Deassert request, or present a new result, by the next edge.
  - A request high during the grant cycle is ignored for that edge, so one station is granted at most every other cycle.
- flush=1 at an edge:
  - all bus_asserted, bus_source, bus_value and grant ←0;
  - no grants issued that edge;
  - ptr unchanged.
  - Pending requests remain and are arbitrated normally after flush drops.
- reset (async): grant, bus_asserted, bus_source, bus_value ←0 and ptr←0 immediately, independent of clock. Reset asserted mid-broadcast kills the broadcast in the same cycle.

## Timing

- Latency: a request eligible at edge N appears on a bus and on grant for exactly the cycle after edge N.
- Each broadcast lasts one cycle. There is no back-pressure from listeners.
- No combinational path from request or request_value to any output.
- Throughput: BUS_COUNT results/cycle aggregate; 1 result per 2 cycles per station.
- A station never appears on two buses in the same cycle.
- Simultaneous flush and request: flush wins.
- Simultaneous reset and anything: reset wins.

## Test plan

Common configuration: SIZE=32, STATION_INDEX_SIZE=2, STATION_COUNT=4, BUS_COUNT=2.

- Reset, then request=4'b1111 with values 0xA0..0xA3 held until granted:
  - edge 1 → bus0 src0/0xA0, bus1 src1/0xA1, grant=0011, ptr=2;
  - edge 2 → bus0 src2/0xA2, bus1 src3/0xA3, grant=1100, ptr=0.
- Wrap-around: from ptr=0, only request[3]=1 (0x33):
  - edge 1 → bus0 src3/0x33, bus1 idle (asserted 0, source 0, value 0), ptr=0;
  - then request=0101 → bus0 src0, bus1 src2, ptr=3.
- Grant masking: station 1 keeps request high with 0x11 through its grant cycle:
  - no bus carries src1 on the following edge;
  - src1/0x11 is granted again on the edge after that.
- Idle: request=0000 for 3 cycles → all outputs 0, ptr unchanged.
- Flush: request=1111 and flush=1 at edge 1:
  - all outputs 0, ptr unchanged;
  - flush=0 at edge 2 → normal grants of src ptr and src ptr+1.
- Async reset pulse between edges while bus_asserted=11:
  - all outputs 0 immediately, without a clock edge;
  - after release, the first grant starts at src0.

Source files
------------

// File: rtl/result_bus_arbiter_if.sv
// rtl/result_bus_arbiter_if.sv - result request/broadcast bundle between stations, arbiter and listeners
// master is the arbiter side; slave is the station/listener side.
interface result_bus_arbiter_if #(
  parameter int SIZE               = 32,
  parameter int STATION_INDEX_SIZE = 1,
  parameter int STATION_COUNT      = 2,
  parameter int BUS_COUNT          = 1
);
  logic                                  flush;
  logic [STATION_COUNT-1:0]              request;
  logic [SIZE*STATION_COUNT-1:0]         request_value;
  logic [STATION_COUNT-1:0]              grant;
  logic [BUS_COUNT-1:0]                  bus_asserted;
  logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source;
  logic [SIZE*BUS_COUNT-1:0]             bus_value;

  modport master (
    input  flush, request, request_value,
    output grant, bus_asserted, bus_source, bus_value
  );

  modport slave (
    output flush, request, request_value,
    input  grant, bus_asserted, bus_source, bus_value
  );
endinterface

// File: rtl/result_bus_arbiter.sv
// rtl/result_bus_arbiter.sv - round-robin sharing of BUS_COUNT result buses among STATION_COUNT stations
// All outputs are registered; requests feed only the next-state logic.
module result_bus_arbiter #(
  parameter int SIZE               = 32,
  parameter int STATION_INDEX_SIZE = 1,
  parameter int STATION_COUNT      = 2,
  parameter int BUS_COUNT          = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  result_bus_arbiter_if.master  bus
);
  localparam int IW = STATION_INDEX_SIZE;

  logic [IW-1:0]              r_ptr;
  logic [STATION_COUNT-1:0]   r_grant;
  logic [BUS_COUNT-1:0]       r_asserted;
  logic [IW*BUS_COUNT-1:0]    r_source;
  logic [SIZE*BUS_COUNT-1:0]  r_value;

  logic [IW-1:0]              w_next_ptr;
  logic [STATION_COUNT-1:0]   w_next_grant;
  logic [BUS_COUNT-1:0]       w_next_asserted;
  logic [IW*BUS_COUNT-1:0]    w_next_source;
  logic [SIZE*BUS_COUNT-1:0]  w_next_value;
  int                         w_fill;
  int                         w_idx;

  // Walk stations from the pointer, wrapping at STATION_COUNT; a station
  // still showing its grant is skipped so a stale request is never re-sent.
  always_comb begin
    w_next_ptr      = r_ptr;
    w_next_grant    = '0;
    w_next_asserted = '0;
    w_next_source   = '0;
    w_next_value    = '0;
    w_fill          = 0;
    w_idx           = 0;
    for (int o = 0; o < STATION_COUNT; o++) begin
      w_idx = int'(r_ptr) + o;
      if (w_idx >= STATION_COUNT) begin
        w_idx = w_idx - STATION_COUNT;
      end
      if ((w_fill < BUS_COUNT) && bus.request[w_idx] && !r_grant[w_idx]) begin
        w_next_asserted[w_fill]            = 1'b1;
        w_next_source[w_fill*IW +: IW]     = IW'(w_idx);
        w_next_value[w_fill*SIZE +: SIZE]  = bus.request_value[w_idx*SIZE +: SIZE];
        w_next_grant[w_idx]                = 1'b1;
        w_next_ptr = (w_idx + 1 == STATION_COUNT) ? '0 : IW'(w_idx + 1);
        w_fill = w_fill + 1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_asserted <= '0;
      r_source   <= '0;
      r_value    <= '0;
    end else if (bus.flush) begin
      r_grant    <= '0;
      r_asserted <= '0;
      r_source   <= '0;
      r_value    <= '0;
    end else begin
      r_ptr      <= w_next_ptr;
      r_grant    <= w_next_grant;
      r_asserted <= w_next_asserted;
      r_source   <= w_next_source;
      r_value    <= w_next_value;
    end
  end

  assign bus.grant        = r_grant;
  assign bus.bus_asserted = r_asserted;
  assign bus.bus_source   = r_source;
  assign bus.bus_value    = r_value;
endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb/tb_result_bus_arbiter.sv - vector table, corner sequences and random run against a queue-based model
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_result_bus_arbiter;
  localparam int SIZE = 32;
  localparam int IW   = 2;
  localparam int SC   = 4;
  localparam int BC   = 2;

  typedef struct {
    logic                flush;
    logic [SC-1:0]       req;
    logic [SIZE*SC-1:0]  val;
    logic [BC-1:0]       ea;
    logic [IW*BC-1:0]    es;
    logic [SIZE*BC-1:0]  ev;
    logic [SC-1:0]       eg;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  result_bus_arbiter_if #(.SIZE(SIZE), .STATION_INDEX_SIZE(IW),
                          .STATION_COUNT(SC), .BUS_COUNT(BC)) bus_if ();

  result_bus_arbiter #(.SIZE(SIZE), .STATION_INDEX_SIZE(IW),
                       .STATION_COUNT(SC), .BUS_COUNT(BC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic check(input string name, input logic [BC-1:0] ea, input logic [IW*BC-1:0] es,
                       input logic [SIZE*BC-1:0] ev, input logic [SC-1:0] eg);
    vectors++;
    if (bus_if.bus_asserted !== ea || bus_if.bus_source !== es ||
        bus_if.bus_value !== ev || bus_if.grant !== eg) begin
      miscompares++;
      $display("FAIL %s: got asserted=%b source=%h value=%h grant=%b, want asserted=%b source=%h value=%h grant=%b",
               name, bus_if.bus_asserted, bus_if.bus_source, bus_if.bus_value, bus_if.grant,
               ea, es, ev, eg);
    end
  endtask

  initial begin
    vec_t               vecs[13];
    logic [SIZE*SC-1:0] va;
    logic [SIZE*SC-1:0] rv;
    logic [SC-1:0]      rq;
    logic [SC-1:0]      mg;
    logic [SC-1:0]      ng;
    logic [BC-1:0]      ea;
    logic [IW*BC-1:0]   es;
    logic [SIZE*BC-1:0] ev;
    logic               fl;
    int                 mptr;
    int                 n;
    int                 q[$];

    va = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    vecs[0]  = '{1'b0, 4'b1111, va, 2'b11, {2'd1, 2'd0}, {32'hA1, 32'hA0}, 4'b0011};
    vecs[1]  = '{1'b0, 4'b1100, va, 2'b11, {2'd3, 2'd2}, {32'hA3, 32'hA2}, 4'b1100};
    vecs[2]  = '{1'b0, 4'b0000, '0, 2'b00, '0, '0, 4'b0000};
    vecs[3]  = '{1'b0, 4'b1000, {32'h33, 96'h0}, 2'b01, {2'd0, 2'd3}, {32'h0, 32'h33}, 4'b1000};
    vecs[4]  = '{1'b0, 4'b0101, {32'h0, 32'h52, 32'h0, 32'h50}, 2'b11, {2'd2, 2'd0},
                 {32'h52, 32'h50}, 4'b0101};
    vecs[5]  = '{1'b0, 4'b0010, {64'h0, 32'h11, 32'h0}, 2'b01, {2'd0, 2'd1}, {32'h0, 32'h11}, 4'b0010};
    vecs[6]  = '{1'b0, 4'b0010, {64'h0, 32'h11, 32'h0}, 2'b00, '0, '0, 4'b0000};
    vecs[7]  = '{1'b0, 4'b0010, {64'h0, 32'h11, 32'h0}, 2'b01, {2'd0, 2'd1}, {32'h0, 32'h11}, 4'b0010};
    vecs[8]  = '{1'b0, 4'b0000, '0, 2'b00, '0, '0, 4'b0000};
    vecs[9]  = '{1'b0, 4'b0000, '0, 2'b00, '0, '0, 4'b0000};
    vecs[10] = '{1'b0, 4'b0000, '0, 2'b00, '0, '0, 4'b0000};
    vecs[11] = '{1'b1, 4'b1111, va, 2'b00, '0, '0, 4'b0000};
    vecs[12] = '{1'b0, 4'b1111, va, 2'b11, {2'd3, 2'd2}, {32'hA3, 32'hA2}, 4'b1100};

    reset = 1'b1;
    bus_if.flush = 1'b0;
    bus_if.request = '0;
    bus_if.request_value = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", '0, '0, '0, '0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      bus_if.flush = vecs[i].flush;
      bus_if.request = vecs[i].req;
      bus_if.request_value = vecs[i].val;
      @(posedge clock);
      #1;
      check($sformatf("table_%0d", i), vecs[i].ea, vecs[i].es, vecs[i].ev, vecs[i].eg);
    end

    // Both buses busy here; reset between edges must clear them at once.
    bus_if.flush = 1'b0;
    bus_if.request = '0;
    #2 reset = 1'b1;
    #1;
    check("async_reset_immediate", '0, '0, '0, '0);
    #2 reset = 1'b0;
    bus_if.request = 4'b1111;
    bus_if.request_value = va;
    @(posedge clock);
    #1;
    check("after_async_reset", 2'b11, {2'd1, 2'd0}, {32'hA1, 32'hA0}, 4'b0011);

    bus_if.request = '0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mptr = 0;
    mg = '0;
    rq = '0;
    rv = '0;
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < SC; j++) begin
        if (mg[j]) begin
          rq[j] = ($urandom % 2) == 0;
          if (rq[j]) rv[j*SIZE +: SIZE] = $urandom;
        end else if (!rq[j] && ($urandom % 3) == 0) begin
          rq[j] = 1'b1;
          rv[j*SIZE +: SIZE] = $urandom;
        end
      end
      fl = ($urandom % 8) == 0;
      bus_if.request = rq;
      bus_if.request_value = rv;
      bus_if.flush = fl;

      ea = '0;
      es = '0;
      ev = '0;
      ng = '0;
      if (!fl) begin
        q.delete();
        for (int o = 0; o < SC; o++) begin
          if (rq[(mptr + o) % SC] && !mg[(mptr + o) % SC]) q.push_back((mptr + o) % SC);
        end
        n = (q.size() < BC) ? q.size() : BC;
        for (int k = 0; k < n; k++) begin
          ea[k] = 1'b1;
          es[k*IW +: IW] = IW'(q[k]);
          ev[k*SIZE +: SIZE] = rv[q[k]*SIZE +: SIZE];
          ng[q[k]] = 1'b1;
        end
        if (n > 0) mptr = (q[n-1] + 1) % SC;
      end
      mg = ng;

      @(posedge clock);
      #1;
      check($sformatf("random_%0d", c), ea, es, ev, ng);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
